serial_pattern_detector: RTL and testbench
==========================================

Name: serial_pattern_detector

Overview:
Consumes the registered serial bit stream produced by the D flip-flop stage (its q output drives data_in here). It shifts valid bits into a history register and compares them against a fixed PATTERN. It emits a one-cycle match pulse and keeps a saturating count of matches. It is the first control-level consumer of the sampled serial line.

Parameters:
PATTERN_W, 4, pattern length in bits (2..16)
PATTERN, 4'b1011, bit pattern to detect; MSB is the oldest bit received
OVERLAP, 1, 1 = overlapping detection allowed; 0 = history restarts after each match
CNT_W, 8, width of the match counter

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
data_in  input  1  serial bit from the upstream D flip-flop q
data_valid  input  1  qualifies data_in; bits are shifted only when 1
count_clr  input  1  synchronous clear of match_count and count_sat
match  output  1  one-cycle pulse when the last PATTERN_W valid bits equal PATTERN
match_count  output  CNT_W  number of matches since reset or clear, saturating
count_sat  output  1  sticky flag, set when match_count reaches all-ones
history  output  PATTERN_W  current shift-register contents, MSB oldest

Behaviour:
- Reset (reset==0 at a clk edge) has priority over every other input. It clears history, the fill counter, match, match_count and count_sat to 0.
- Internal fill counter (0..PATTERN_W, saturating) tracks the number of valid bits held since reset or restart. Zeros loaded at reset never count as received bits, so PATTERN=0000 cannot match before 4 real bits arrive.
- Edge with data_valid=1:
  - next_hist = {history[PATTERN_W-2:0], data_in}
  - fill increments (saturates at PATTERN_W)
- match is registered. At an edge with data_valid=1, match is set to 1 when both hold:
  - next_hist == PATTERN
  - fill+1 >= PATTERN_W
  Otherwise match is set to 0.
- Latency: match is high during the clk cycle immediately after the edge that sampled the completing bit, and for exactly one cycle.
- Edge with data_valid=0: history and fill hold; match is 0. Bubbles between valid bits do not break a pattern.
- OVERLAP=1: history and fill are untouched by a match, so a pattern suffix can begin the next match. For 1011011, matches occur on bits 4 and 7.
- OVERLAP=0: on the edge that sets match, fill is set to 0. history still shifts, but no match is possible until PATTERN_W further valid bits have arrived.
- Counter update, in priority order:
  - reset
  - count_clr=1: match_count=0, count_sat=0; a match generated on the same edge then counts, giving match_count=1
  - match generated: match_count+1, saturating at 2^CNT_W-1
- count_sat is set on the edge where match_count becomes 2^CNT_W-1. It stays set until reset or count_clr.
- No combinational path exists from inputs to outputs; every output is a flop.

Test Plan:
- PATTERN=1011, OVERLAP=1: reset low for 2 cycles, then valid bits 1,0,1,1 → match=1 for one cycle after the 4th bit edge, match_count=1, history=4'b1011.
- OVERLAP=1: valid stream 1,0,1,1,0,1,1 → match pulses after bits 4 and 7, match_count=2. OVERLAP=0 with the same stream → single pulse after bit 4, match_count=1.
- Bubbles: stream 1,0,1,1 with data_valid=0 for 3 cycles between each bit → one match, asserted after the final valid edge. match=0 throughout all bubble cycles.
- Reset mid-stream: bits 1,0,1, then reset=0 for one edge, then bits 1,1 → no match. history=4'b0011, match_count=0.
- PATTERN=4'b0000 straight out of reset: 3 valid zeros → no match; 4th valid zero → match. A 5th zero with OVERLAP=1 → second match.
- CNT_W=2: 4 overlapping matches → match_count=3 with count_sat=1 after the 3rd match; the 4th match leaves the count at 3. Then count_clr=1 on the same edge as a match → match_count=1, count_sat=0.

Source files
------------

// File: rtl/serial_pattern_detector_if.sv
// Signal bundle between the serial line sampler (master) and the pattern detector (slave).
// data_valid qualifies data_in; there is no backpressure, and every valid bit is consumed on the edge where it is presented.
interface serial_pattern_detector_if #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 8
) ();
    logic                 data_in;
    logic                 data_valid;
    logic                 count_clr;
    logic                 match;
    logic [CNT_W-1:0]     match_count;
    logic                 count_sat;
    logic [PATTERN_W-1:0] history;

    modport master (
        output data_in, data_valid, count_clr,
        input  match, match_count, count_sat, history
    );

    modport slave (
        input  data_in, data_valid, count_clr,
        output match, match_count, count_sat, history
    );
endinterface

// File: rtl/serial_pattern_detector.sv
// Shifts qualified serial bits into a history register and pulses match when the newest bits equal PATTERN.
// Also keeps a saturating match counter with a sticky saturation flag. Every output comes straight from a flop.
module serial_pattern_detector #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_pattern_detector_if.slave bus
);
    localparam int                 FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [PATTERN_W-1:0] hist_q, hist_d;
    logic [PATTERN_W-1:0] next_hist;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 match_q, match_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;
    logic                 sat_q, sat_d, sat_base;

    // fill counts real received bits, so reset zeros in hist_q can never form a match.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        next_hist = {hist_q[PATTERN_W-2:0], bus.data_in};
        if (bus.data_valid) begin
            hist_d = next_hist;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            if ((next_hist == PATTERN) && (fill_q >= FILL_LAST)) begin
                match_d = 1'b1;
                if (!OVERLAP) begin
                    fill_d = '0;
                end
            end
        end
    end

    // A clear and a match on the same edge leave the count at one.
    always_comb begin
        cnt_base = bus.count_clr ? '0 : cnt_q;
        sat_base = bus.count_clr ? 1'b0 : sat_q;
        cnt_d    = cnt_base;
        if (match_d && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + 1'b1;
        end
        sat_d = sat_base | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = cnt_q;
    assign bus.count_sat   = sat_q;
    assign bus.history     = hist_q;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: four instances with different parameters, directed streams,
// and a match monitor that pops expected {dut, count_sat, match_count} entries from a queue.
module tb_serial_pattern_detector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic drv_data[4];
    logic drv_valid[4];
    logic drv_clr[4];

    logic       obs_match[4];
    logic       obs_sat[4];
    logic [7:0] obs_cnt[4];
    logic [3:0] obs_hist[4];

    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    int n_vec = 0;
    int n_err = 0;

    // dut0: 1011 overlapping, dut1: 1011 non-overlapping, dut2: 0000 overlapping, dut3: 1011 with 2-bit counter
    serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if0 ();
    serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if1 ();
    serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if2 ();
    serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(2)) if3 ();

    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
        dut0 (.clk(clk), .reset(rst_n), .bus(if0));
    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
        dut1 (.clk(clk), .reset(rst_n), .bus(if1));
    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8))
        dut2 (.clk(clk), .reset(rst_n), .bus(if2));
    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
        dut3 (.clk(clk), .reset(rst_n), .bus(if3));

    assign if0.data_in = drv_data[0];  assign if0.data_valid = drv_valid[0];  assign if0.count_clr = drv_clr[0];
    assign if1.data_in = drv_data[1];  assign if1.data_valid = drv_valid[1];  assign if1.count_clr = drv_clr[1];
    assign if2.data_in = drv_data[2];  assign if2.data_valid = drv_valid[2];  assign if2.count_clr = drv_clr[2];
    assign if3.data_in = drv_data[3];  assign if3.data_valid = drv_valid[3];  assign if3.count_clr = drv_clr[3];

    assign obs_match[0] = if0.match;  assign obs_sat[0] = if0.count_sat;
    assign obs_match[1] = if1.match;  assign obs_sat[1] = if1.count_sat;
    assign obs_match[2] = if2.match;  assign obs_sat[2] = if2.count_sat;
    assign obs_match[3] = if3.match;  assign obs_sat[3] = if3.count_sat;
    assign obs_cnt[0] = if0.match_count;
    assign obs_cnt[1] = if1.match_count;
    assign obs_cnt[2] = if2.match_count;
    assign obs_cnt[3] = {6'b0, if3.match_count};
    assign obs_hist[0] = if0.history;
    assign obs_hist[1] = if1.history;
    assign obs_hist[2] = if2.history;
    assign obs_hist[3] = if3.history;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every match pulse must correspond to the next expected entry.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (obs_match[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_match dut%0d: got match=1 count=%0d, required no match (t=%0t)",
                             i, obs_cnt[i], $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("match_dut%0d {dut,sat,cnt}", i),
                          {21'b0, i[1:0], obs_sat[i], obs_cnt[i]}, {21'b0, mon_e});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input int d, input logic b, input logic clr);
        drv_data[d]  = b;
        drv_valid[d] = 1'b1;
        drv_clr[d]   = clr;
        tick();
        drv_data[d]  = 1'b0;
        drv_valid[d] = 1'b0;
        drv_clr[d]   = 1'b0;
    endtask

    task automatic send_bits(input int d, input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            send(d, bits[k], 1'b0);
        end
    endtask

    task automatic exp_match(input int d, input logic sat, input logic [7:0] cnt);
        exp_q.push_back({d[1:0], sat, cnt});
    endtask

    task automatic settle_and_drain(input string name);
        tick();
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [3:0] pat;
        for (int i = 0; i < 4; i++) begin
            drv_data[i]  = 1'b0;
            drv_valid[i] = 1'b0;
            drv_clr[i]   = 1'b0;
        end

        // Reset state of every instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_state_dut%0d", i),
                  {17'b0, obs_match[i], obs_sat[i], obs_cnt[i], obs_hist[i]}, 32'd0);
        end

        // Basic 1011 detection
        exp_match(0, 1'b0, 8'd1);
        send_bits(0, 16'b1011, 4);
        settle_and_drain("basic");
        check("basic_history", obs_hist[0], 4'b1011);
        check("basic_count", obs_cnt[0], 8'd1);

        // Overlapping stream 1011011: matches on bits 4 and 7
        do_reset();
        exp_match(0, 1'b0, 8'd1);
        exp_match(0, 1'b0, 8'd2);
        send_bits(0, 16'b1011011, 7);
        settle_and_drain("overlap");
        check("overlap_count", obs_cnt[0], 8'd2);

        // Non-overlapping: only bit 4 matches
        do_reset();
        exp_match(1, 1'b0, 8'd1);
        send_bits(1, 16'b1011011, 7);
        settle_and_drain("no_overlap");
        check("no_overlap_count", obs_cnt[1], 8'd1);
        check("no_overlap_history", obs_hist[1], 4'b1011);

        // Bubbles between valid bits
        do_reset();
        pat = 4'b1011;
        exp_match(0, 1'b0, 8'd1);
        for (int k = 3; k >= 0; k--) begin
            send(0, pat[k], 1'b0);
            for (int j = 0; j < 3; j++) begin
                tick();
                check("bubble_match_low", obs_match[0], 1'b0);
            end
        end
        check("bubble_queue_drained", exp_q.size(), 0);
        check("bubble_count", obs_cnt[0], 8'd1);

        // Reset in the middle of a stream
        do_reset();
        send_bits(0, 16'b101, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send_bits(0, 16'b11, 2);
        settle_and_drain("mid_reset");
        check("mid_reset_history", obs_hist[0], 4'b0011);
        check("mid_reset_count", obs_cnt[0], 8'd0);

        // All-zero pattern needs four real bits
        do_reset();
        send_bits(2, 16'b000, 3);
        tick();
        check("zeros_three_bits_count", obs_cnt[2], 8'd0);
        exp_match(2, 1'b0, 8'd1);
        exp_match(2, 1'b0, 8'd2);
        send_bits(2, 16'b00, 2);
        settle_and_drain("zeros");
        check("zeros_count", obs_cnt[2], 8'd2);

        // 2-bit counter saturation, then clear coinciding with a match
        do_reset();
        exp_match(3, 1'b0, 8'd1);
        exp_match(3, 1'b0, 8'd2);
        exp_match(3, 1'b1, 8'd3);
        exp_match(3, 1'b1, 8'd3);
        send_bits(3, 16'b1011011011011, 13);
        settle_and_drain("sat");
        check("sat_count", obs_cnt[3], 8'd3);
        check("sat_flag", obs_sat[3], 1'b1);
        exp_match(3, 1'b0, 8'd1);
        send(3, 1'b0, 1'b0);
        send(3, 1'b1, 1'b0);
        send(3, 1'b1, 1'b1);
        settle_and_drain("clr_with_match");
        check("clr_with_match_count", obs_cnt[3], 8'd1);
        check("clr_with_match_sat", obs_sat[3], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
